// File: rtl/mem_read_arbiter_if.sv
// Read-channel bundle between two requesting masters, the arbiter and one memory slave.
// slave modport is the arbiter's view; master modport is the masters-plus-memory environment.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic [1:0]          m_ARvalid;
  logic [1:0]          m_ARready;
  logic [2*ADDR_W-1:0] m_ARdata;
  logic [5:0]          m_ARprot;
  logic [1:0]          m_Rvalid;
  logic [1:0]          m_RReady;
  logic [31:0]         m_Rdata;
  logic                s_ARvalid;
  logic                s_ARready;
  logic [ADDR_W-1:0]   s_ARdata;
  logic [2:0]          s_ARprot;
  logic                s_Rvalid;
  logic                s_RReady;
  logic [31:0]         s_Rdata;
  logic [1:0]          grant;

  modport slave (
    input  m_ARvalid, m_ARdata, m_ARprot, m_RReady, s_ARready, s_Rvalid, s_Rdata,
    output m_ARready, m_Rvalid, m_Rdata, s_ARvalid, s_ARdata, s_ARprot, s_RReady, grant
  );

  modport master (
    output m_ARvalid, m_ARdata, m_ARprot, m_RReady, s_ARready, s_Rvalid, s_Rdata,
    input  m_ARready, m_Rvalid, m_Rdata, s_ARvalid, s_ARdata, s_ARprot, s_RReady, grant
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-master round-robin read arbiter onto one memory slave, one transaction in flight.
// Address phase is registered (ready pulse + s_ARvalid one cycle after the request); data phase is a combinational pass-through.
module mem_read_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  mem_read_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              last;
  logic              owner;
  logic              pick;
  logic [1:0]        grant_q;
  logic [1:0]        ar_ready_q;
  logic              s_ar_valid_q;
  logic [ADDR_W-1:0] s_ar_data_q;
  logic [2:0]        s_ar_prot_q;
  logic              in_data;

  // Contested round goes to whoever did not win last; otherwise the lone requester.
  always_comb begin
    pick = 1'b0;
    if (bus.m_ARvalid == 2'b11) pick = ~last;
    else                        pick = bus.m_ARvalid[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      grant_q      <= 2'b00;
      ar_ready_q   <= 2'b00;
      s_ar_valid_q <= 1'b0;
      s_ar_data_q  <= '0;
      s_ar_prot_q  <= 3'b000;
    end else begin
      ar_ready_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|bus.m_ARvalid) begin
            owner        <= pick;
            grant_q      <= pick ? 2'b10 : 2'b01;
            ar_ready_q   <= pick ? 2'b10 : 2'b01;
            s_ar_valid_q <= 1'b1;
            s_ar_data_q  <= pick ? bus.m_ARdata[2*ADDR_W-1:ADDR_W] : bus.m_ARdata[ADDR_W-1:0];
            s_ar_prot_q  <= pick ? bus.m_ARprot[5:3] : bus.m_ARprot[2:0];
            state        <= ADDR;
          end
        end
        ADDR: begin
          if (s_ar_valid_q && bus.s_ARready) begin
            s_ar_valid_q <= 1'b0;
            last         <= owner;
            state        <= DATA;
          end
        end
        DATA: begin
          if (bus.s_Rvalid && bus.m_RReady[owner]) begin
            grant_q <= 2'b00;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data phase is gated by rst so a pending reset silences the response immediately.
  assign in_data = (state == DATA) && !rst;

  assign bus.grant     = grant_q;
  assign bus.m_ARready = ar_ready_q;
  assign bus.s_ARvalid = s_ar_valid_q;
  assign bus.s_ARdata  = s_ar_data_q;
  assign bus.s_ARprot  = s_ar_prot_q;
  assign bus.m_Rvalid  = in_data ? (grant_q & {2{bus.s_Rvalid}}) : 2'b00;
  assign bus.s_RReady  = in_data && bus.m_RReady[owner];
  assign bus.m_Rdata   = bus.s_Rdata;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: inputs driven and outputs sampled mid-cycle (after negedge).
module tb_mem_read_arbiter;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_read_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_read_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_defaults();
    bus.m_ARvalid = 2'b00;
    bus.m_ARdata  = '0;
    bus.m_ARprot  = 6'b0;
    bus.m_RReady  = 2'b11;
    bus.s_ARready = 1'b1;
    bus.s_Rvalid  = 1'b1;
    bus.s_Rdata   = 32'h0;
  endtask

  task automatic test_reset();
    drive_defaults();
    rst = 1'b1;
    cyc(); cyc();
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", bus.grant); end
    checks++; if (bus.m_ARready !== 2'b00) begin errors++; $display("FAIL reset_arready got %b want 00", bus.m_ARready); end
    checks++; if (bus.s_ARvalid !== 1'b0) begin errors++; $display("FAIL reset_s_arvalid got %b want 0", bus.s_ARvalid); end
    checks++; if (bus.s_RReady !== 1'b0) begin errors++; $display("FAIL reset_s_rready got %b want 0", bus.s_RReady); end
    checks++; if (bus.m_Rvalid !== 2'b00) begin errors++; $display("FAIL reset_m_rvalid got %b want 00", bus.m_Rvalid); end
    checks++; if (bus.s_ARdata !== 32'h0 || bus.s_ARprot !== 3'b000) begin errors++; $display("FAIL reset_s_ar got %h/%b want 0/000", bus.s_ARdata, bus.s_ARprot); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bus.m_ARvalid = 2'b01;
    bus.m_ARdata  = {32'hFFFF_0000, 32'h0000_0100};
    bus.m_ARprot  = 6'b111_010;
    bus.s_Rdata   = 32'hDEADBEEF;
    checks++; if (bus.m_ARready !== 2'b00) begin errors++; $display("FAIL single_idle_arready got %b want 00", bus.m_ARready); end
    cyc();
    checks++; if (bus.m_ARready !== 2'b01) begin errors++; $display("FAIL single_arready got %b want 01", bus.m_ARready); end
    checks++; if (bus.s_ARvalid !== 1'b1 || bus.s_ARdata !== 32'h100) begin errors++; $display("FAIL single_s_ar got %b/%h want 1/00000100", bus.s_ARvalid, bus.s_ARdata); end
    checks++; if (bus.s_ARprot !== 3'b010 || bus.grant !== 2'b01) begin errors++; $display("FAIL single_prot_grant got %b/%b want 010/01", bus.s_ARprot, bus.grant); end
    checks++; if (bus.m_Rvalid !== 2'b00 || bus.s_RReady !== 1'b0) begin errors++; $display("FAIL single_addr_rside got %b/%b want 00/0", bus.m_Rvalid, bus.s_RReady); end
    cyc();
    bus.m_ARvalid = 2'b00;
    checks++; if (bus.m_Rvalid !== 2'b01 || bus.m_Rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %b/%h want 01/deadbeef", bus.m_Rvalid, bus.m_Rdata); end
    checks++; if (bus.s_RReady !== 1'b1 || bus.s_ARvalid !== 1'b0 || bus.m_ARready !== 2'b00) begin errors++; $display("FAIL single_data_ctrl got %b/%b/%b want 1/0/00", bus.s_RReady, bus.s_ARvalid, bus.m_ARready); end
    cyc();
    checks++; if (bus.grant !== 2'b00 || bus.m_Rvalid !== 2'b00) begin errors++; $display("FAIL single_done got %b/%b want 00/00", bus.grant, bus.m_Rvalid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [4];
    int n;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    n = 0;
    rst = 1'b1;
    bus.m_ARvalid = 2'b11;
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      checks++; if (bus.m_ARready === 2'b11) begin errors++; $display("FAIL rr_both_ready at cycle %0d got 11 want not 11", k); end
      if (bus.m_ARready !== 2'b00 && n < 4) begin
        checks++; if (bus.grant !== exp_order[n]) begin errors++; $display("FAIL rr_order[%0d] got %b want %b", n, bus.grant, exp_order[n]); end
        n++;
      end
    end
    bus.m_ARvalid = 2'b00;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got %0d want 4", n); end
    cyc(); cyc();
  endtask

  task automatic test_addr_stall();
    int pulses;
    pulses = 0;
    bus.m_ARvalid = 2'b01;
    bus.m_ARdata  = {32'h0, 32'h0000_0200};
    bus.s_ARready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 2) bus.m_ARvalid = 2'b00;
      if (bus.m_ARready !== 2'b00) pulses++;
      checks++; if (bus.s_ARvalid !== 1'b1 || bus.s_ARdata !== 32'h200) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h want 1/00000200", k, bus.s_ARvalid, bus.s_ARdata); end
    end
    bus.s_ARready = 1'b1;
    cyc();
    if (bus.m_ARready !== 2'b00) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    checks++; if (bus.m_Rvalid !== 2'b01) begin errors++; $display("FAIL stall_data got %b want 01", bus.m_Rvalid); end
    cyc();
  endtask

  task automatic test_backpressure();
    bus.m_ARvalid = 2'b10;
    bus.m_ARdata  = {32'h0000_0300, 32'h0000_0400};
    bus.m_RReady  = 2'b01;
    cyc();
    checks++; if (bus.m_ARready !== 2'b10 || bus.s_ARdata !== 32'h300) begin errors++; $display("FAIL bp_grant got %b/%h want 10/00000300", bus.m_ARready, bus.s_ARdata); end
    bus.m_ARvalid = 2'b11;
    for (int k = 2; k <= 4; k++) begin
      cyc();
      bus.m_ARvalid = 2'b01;
      #1;
      checks++; if (bus.s_RReady !== 1'b0 || bus.m_Rvalid !== 2'b10) begin errors++; $display("FAIL bp_stall[%0d] got %b/%b want 0/10", k, bus.s_RReady, bus.m_Rvalid); end
      checks++; if (bus.m_ARready !== 2'b00 || bus.grant !== 2'b10) begin errors++; $display("FAIL bp_no_m0[%0d] got %b/%b want 00/10", k, bus.m_ARready, bus.grant); end
    end
    bus.m_RReady = 2'b11;
    #1;
    checks++; if (bus.s_RReady !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", bus.s_RReady); end
    cyc();
    checks++; if (bus.grant !== 2'b00 || bus.m_ARready !== 2'b00) begin errors++; $display("FAIL bp_dead got %b/%b want 00/00", bus.grant, bus.m_ARready); end
    cyc();
    checks++; if (bus.m_ARready !== 2'b01 || bus.s_ARdata !== 32'h400) begin errors++; $display("FAIL bp_m0_served got %b/%h want 01/00000400", bus.m_ARready, bus.s_ARdata); end
    cyc();
    bus.m_ARvalid = 2'b00;
    cyc();
  endtask

  task automatic test_late_requester();
    bus.m_ARvalid = 2'b01;
    bus.m_ARdata  = {32'h0000_0600, 32'h0000_0500};
    cyc();
    bus.m_ARvalid = 2'b11;
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL late_first got %b want 01", bus.grant); end
    cyc();
    bus.m_ARvalid = 2'b10;
    checks++; if (bus.m_Rvalid !== 2'b01) begin errors++; $display("FAIL late_m0_data got %b want 01", bus.m_Rvalid); end
    cyc();
    checks++; if (bus.grant !== 2'b00 || bus.m_ARready !== 2'b00) begin errors++; $display("FAIL late_dead got %b/%b want 00/00", bus.grant, bus.m_ARready); end
    cyc();
    checks++; if (bus.grant !== 2'b10 || bus.m_ARready !== 2'b10 || bus.s_ARdata !== 32'h600) begin errors++; $display("FAIL late_m1 got %b/%b/%h want 10/10/00000600", bus.grant, bus.m_ARready, bus.s_ARdata); end
    cyc();
    bus.m_ARvalid = 2'b00;
    cyc();
  endtask

  task automatic test_reset_mid_data();
    bus.m_ARvalid = 2'b01;
    bus.m_ARdata  = {32'h0000_0800, 32'h0000_0700};
    bus.s_Rvalid  = 1'b0;
    cyc();
    cyc();
    bus.m_ARvalid = 2'b00;
    checks++; if (bus.grant !== 2'b01 || bus.s_RReady !== 1'b1) begin errors++; $display("FAIL rmd_in_data got %b/%b want 01/1", bus.grant, bus.s_RReady); end
    rst = 1'b1;
    bus.s_Rvalid = 1'b1;
    #1;
    checks++; if (bus.m_Rvalid !== 2'b00) begin errors++; $display("FAIL rmd_rvalid_in_rst got %b want 00", bus.m_Rvalid); end
    cyc();
    bus.m_ARvalid = 2'b11;
    checks++; if (bus.grant !== 2'b00 || bus.s_ARvalid !== 1'b0 || bus.m_Rvalid !== 2'b00) begin errors++; $display("FAIL rmd_after got %b/%b/%b want 00/0/00", bus.grant, bus.s_ARvalid, bus.m_Rvalid); end
    checks++; if (bus.s_ARdata !== 32'h0) begin errors++; $display("FAIL rmd_addr_clr got %h want 0", bus.s_ARdata); end
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (bus.grant !== 2'b01 || bus.m_ARready !== 2'b01) begin errors++; $display("FAIL rmd_first_contest got %b/%b want 01/01", bus.grant, bus.m_ARready); end
    bus.m_ARvalid = 2'b00;
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_addr_stall();
    test_backpressure();
    test_late_requester();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
